bz_flit_deserializer: RTL and testbench

Parametrised flit-to-word deserializer between the router's incoming flit FIFO and the BrainScales/Braindrop core input channel. Consumes tail-marked flits from a show-ahead FIFO, strips the header flit, assembles NFlits data flits MSB-first into one core word, and presents it on a valid/ack Channel. Unlike the fixed 3-flit predecessor, it supports:

- arbitrary flit width and flit count;
- optional headerless operation;
- one flit per cycle with an output register that overlaps collection with the ack wait;
- detection and counting of truncated packets.

---
 rtl/bz_flit_deserializer.sv | 103 ++++++++++
 tb/tb_bz_flit_deserializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bz_flit_deserializer.sv
// Flit-to-word deserializer: pops tail-marked flits from a show-ahead FIFO, drops the optional
// header, packs NFlits payloads MSB-first into one core word and offers it on a valid/ack channel.
module bz_flit_deserializer #(
    parameter int NFlitData = 10,
    parameter int NFlits    = 3,
    parameter int NOut      = 32,
    parameter int HasHeader = 1,
    parameter int NErr      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 isempty,
    input  logic [NFlitData:0]   data_in,
    output logic                 rdreq,
    output logic [NOut-1:0]      PC_out_channel_d,
    output logic                 PC_out_channel_v,
    input  logic                 PC_out_channel_a,
    output logic [NErr-1:0]      err_count,
    output logic                 dbg_state
);
    localparam int NWord = NFlits * NFlitData;
    localparam int CntW  = (NFlits > 1) ? $clog2(NFlits) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NFlits - 1);

    typedef enum logic { S_HEAD = 1'b0, S_COLLECT = 1'b1 } state_t;
    localparam state_t StIdle = (HasHeader != 0) ? S_HEAD : S_COLLECT;

    if (NOut < NWord) begin : g_bad_width
        $error("bz_flit_deserializer: NOut must be >= NFlits*NFlitData");
    end

    state_t            state;
    logic [CntW-1:0]   cnt;
    logic [NWord-1:0]  asm_q;
    logic [NWord-1:0]  asm_next;
    logic              tail;
    logic [NFlitData-1:0] payload;
    logic              last_flit;
    logic              can_accept;

    assign tail      = data_in[NFlitData];
    assign payload   = data_in[NFlitData-1:0];
    assign last_flit = (state == S_COLLECT) && (cnt == CntLast);

    // Channel: a word transfers on any edge with v=1 and a=1; v/d hold until then, a is ignored
    // while v=0. The final flit of a word is only popped once the output register is free.
    assign can_accept = !last_flit || !PC_out_channel_v || PC_out_channel_a;
    assign rdreq      = can_accept && !isempty && !reset;
    assign dbg_state  = state;

    // Place the current payload in its slot; on the final flit this yields the complete word.
    always_comb begin
        asm_next = asm_q;
        for (int k = 0; k < NFlits; k++) begin
            if (cnt == CntW'(k)) begin
                asm_next[(NFlits-k)*NFlitData-1 -: NFlitData] = payload;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= StIdle;
            cnt              <= '0;
            asm_q            <= '0;
            PC_out_channel_d <= '0;
            PC_out_channel_v <= 1'b0;
            err_count        <= '0;
        end else begin
            if (PC_out_channel_v && PC_out_channel_a) begin
                PC_out_channel_v <= 1'b0;
            end
            if (rdreq) begin
                if (state == S_HEAD) begin
                    // A tail on the header is an empty packet; stay and wait for the next header.
                    if (!tail) begin
                        state <= S_COLLECT;
                    end
                end else if (cnt != CntLast) begin
                    if (tail) begin
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                        cnt   <= '0;
                        asm_q <= '0;
                        state <= StIdle;
                    end else begin
                        asm_q <= asm_next;
                        cnt   <= cnt + 1'b1;
                    end
                end else begin
                    PC_out_channel_d <= NOut'(asm_next);
                    PC_out_channel_v <= 1'b1;
                    cnt              <= '0;
                    asm_q            <= '0;
                    if (tail) begin
                        state <= StIdle;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_bz_flit_deserializer.sv
// Directed bench for bz_flit_deserializer: three instances (default, 8x4 headerless, 2-bit
// error counter) fed from modelled show-ahead FIFOs, with an expected-word queue per instance.
module tb_bz_flit_deserializer;
    logic clk;
    logic rst0, rst1, rst2;
    logic isempty0, isempty1, isempty2;
    logic [10:0] data_in0, data_in2;
    logic [8:0]  data_in1;
    logic rdreq0, rdreq1, rdreq2;
    logic [31:0] d0, d1, d2;
    logic v0, v1, v2;
    logic a0, a1, a2;
    logic [15:0] err0, err1;
    logic [1:0]  err2;
    logic dbg0, dbg1, dbg2;

    logic [10:0] fifo0[$];
    logic [8:0]  fifo1[$];
    logic [10:0] fifo2[$];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];

    logic pop0, pop1, pop2;
    int   errors;
    int   checks;

    bz_flit_deserializer u_dut0 (
        .clk(clk), .reset(rst0), .isempty(isempty0), .data_in(data_in0), .rdreq(rdreq0),
        .PC_out_channel_d(d0), .PC_out_channel_v(v0), .PC_out_channel_a(a0),
        .err_count(err0), .dbg_state(dbg0)
    );

    bz_flit_deserializer #(.NFlitData(8), .NFlits(4), .NOut(32), .HasHeader(0), .NErr(16)) u_dut1 (
        .clk(clk), .reset(rst1), .isempty(isempty1), .data_in(data_in1), .rdreq(rdreq1),
        .PC_out_channel_d(d1), .PC_out_channel_v(v1), .PC_out_channel_a(a1),
        .err_count(err1), .dbg_state(dbg1)
    );

    bz_flit_deserializer #(.NErr(2)) u_dut2 (
        .clk(clk), .reset(rst2), .isempty(isempty2), .data_in(data_in2), .rdreq(rdreq2),
        .PC_out_channel_d(d2), .PC_out_channel_v(v2), .PC_out_channel_a(a2),
        .err_count(err2), .dbg_state(dbg2)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] fl(input logic t, input logic [9:0] p);
        return {t, p};
    endfunction

    function automatic logic [8:0] fl8(input logic t, input logic [7:0] p);
        return {t, p};
    endfunction

    task automatic drive();
        isempty0 = (fifo0.size() == 0);
        isempty1 = (fifo1.size() == 0);
        isempty2 = (fifo2.size() == 0);
        data_in0 = isempty0 ? '0 : fifo0[0];
        data_in1 = isempty1 ? '0 : fifo1[0];
        data_in2 = isempty2 ? '0 : fifo2[0];
    endtask

    // One clock cycle: settle inputs, sample pops and transfers for the coming edge, then pop.
    task automatic step();
        drive();
        #1;
        pop0 = rdreq0;
        pop1 = rdreq1;
        pop2 = rdreq2;
        check("rdreq_while_empty",
              32'((rdreq0 & isempty0) | (rdreq1 & isempty1) | (rdreq2 & isempty2)), 32'd0);
        if (!rst0 && v0 && a0) begin
            check("dut0_word_expected", 32'(exp_q0.size() > 0), 32'd1);
            if (exp_q0.size() > 0) check("dut0_word", d0, exp_q0.pop_front());
        end
        if (!rst1 && v1 && a1) begin
            check("dut1_word_expected", 32'(exp_q1.size() > 0), 32'd1);
            if (exp_q1.size() > 0) check("dut1_word", d1, exp_q1.pop_front());
        end
        if (!rst2 && v2 && a2) begin
            check("dut2_word_expected", 32'(exp_q2.size() > 0), 32'd1);
            if (exp_q2.size() > 0) check("dut2_word", d2, exp_q2.pop_front());
        end
        @(negedge clk);
        if (pop0 && fifo0.size() > 0) void'(fifo0.pop_front());
        if (pop1 && fifo1.size() > 0) void'(fifo1.pop_front());
        if (pop2 && fifo2.size() > 0) void'(fifo2.pop_front());
        drive();
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        a0 = 1'b1; a1 = 1'b1; a2 = 1'b1;
        pop0 = 1'b0; pop1 = 1'b0; pop2 = 1'b0;
        drive();
        @(negedge clk);

        // Reset state, with flits already waiting in the FIFO.
        fifo0.push_back(fl(0, 10'h07F));
        fifo0.push_back(fl(0, 10'h3AB));
        fifo0.push_back(fl(0, 10'h155));
        fifo0.push_back(fl(1, 10'h2CC));
        step();
        step();
        check("reset_rdreq0", 32'(rdreq0), 32'd0);
        check("reset_v0", 32'(v0), 32'd0);
        check("reset_d0", d0, 32'd0);
        check("reset_err0", 32'(err0), 32'd0);
        check("reset_state0_head", 32'(dbg0), 32'd0);
        check("reset_state1_collect", 32'(dbg1), 32'd1);
        check("reset_err2", 32'(err2), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // Single 3-flit word, prompt ack.
        exp_q0.push_back(32'h3AB5_56CC);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_rdreq_run", 32'(pop0), 32'd1);
            if (i < 3) check("t1_v_early", 32'(v0), 32'd0);
        end
        check("t1_v", 32'(v0), 32'd1);
        check("t1_d", d0, 32'h3AB5_56CC);
        step();
        check("t1_idle_pop", 32'(pop0), 32'd0);
        check("t1_v_one_cycle", 32'(v0), 32'd0);

        // Two-word packet under backpressure.
        a0 = 1'b0;
        fifo0.push_back(fl(0, 10'h000));
        fifo0.push_back(fl(0, 10'h001));
        fifo0.push_back(fl(0, 10'h002));
        fifo0.push_back(fl(0, 10'h003));
        fifo0.push_back(fl(0, 10'h111));
        fifo0.push_back(fl(0, 10'h222));
        fifo0.push_back(fl(1, 10'h333));
        exp_q0.push_back(32'h0010_0803);
        exp_q0.push_back(32'h1118_8B33);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t2_early_pop", 32'(pop0), 32'd1);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            check("t2_hold_pop", 32'(pop0), 32'd0);
            check("t2_hold_v", 32'(v0), 32'd1);
            check("t2_hold_d", d0, 32'h0010_0803);
        end
        a0 = 1'b1;
        step();
        check("t2_b2b_pop", 32'(pop0), 32'd1);
        check("t2_b2b_v", 32'(v0), 32'd1);
        check("t2_b2b_d", d0, 32'h1118_8B33);
        step();
        check("t2_v_drop", 32'(v0), 32'd0);
        check("t2_err", 32'(err0), 32'd0);

        // Truncated packet followed by a good one.
        fifo0.push_back(fl(0, 10'h000));
        fifo0.push_back(fl(0, 10'h001));
        fifo0.push_back(fl(1, 10'h002));
        fifo0.push_back(fl(0, 10'h000));
        fifo0.push_back(fl(0, 10'h0AA));
        fifo0.push_back(fl(0, 10'h0BB));
        fifo0.push_back(fl(1, 10'h0CC));
        exp_q0.push_back(32'h0AA2_ECCC);
        for (int i = 0; i < 3; i++) step();
        check("t3_err", 32'(err0), 32'd1);
        check("t3_no_v", 32'(v0), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("t3_queue_drained", 32'(exp_q0.size()), 32'd0);

        // Reset mid-packet, then reset with a word pending.
        a0 = 1'b0;
        fifo0.push_back(fl(0, 10'h000));
        fifo0.push_back(fl(0, 10'h010));
        fifo0.push_back(fl(0, 10'h020));
        for (int i = 0; i < 3; i++) step();
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        check("t5_rst1_v", 32'(v0), 32'd0);
        check("t5_rst1_state", 32'(dbg0), 32'd0);
        fifo0.push_back(fl(0, 10'h3FF));
        fifo0.push_back(fl(0, 10'h100));
        fifo0.push_back(fl(0, 10'h200));
        fifo0.push_back(fl(1, 10'h300));
        for (int i = 0; i < 4; i++) step();
        check("t5_pending_v", 32'(v0), 32'd1);
        check("t5_pending_d", d0, 32'h1008_0300);
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        check("t5_rst2_v", 32'(v0), 32'd0);
        check("t5_rst2_d", d0, 32'd0);
        fifo0.push_back(fl(0, 10'h155));
        fifo0.push_back(fl(0, 10'h001));
        fifo0.push_back(fl(0, 10'h002));
        fifo0.push_back(fl(1, 10'h003));
        a0 = 1'b1;
        exp_q0.push_back(32'h0010_0803);
        for (int i = 0; i < 5; i++) step();
        check("t5_queue_drained", 32'(exp_q0.size()), 32'd0);
        check("t5_err", 32'(err0), 32'd0);

        // Headerless 8-bit x 4 instance, then a one-flit truncation.
        fifo1.push_back(fl8(0, 8'h12));
        fifo1.push_back(fl8(0, 8'h34));
        fifo1.push_back(fl8(0, 8'h56));
        fifo1.push_back(fl8(1, 8'h78));
        exp_q1.push_back(32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_pop", 32'(pop1), 32'd1);
        end
        check("t4_v", 32'(v1), 32'd1);
        check("t4_d", d1, 32'h1234_5678);
        step();
        fifo1.push_back(fl8(1, 8'hAB));
        fifo1.push_back(fl8(0, 8'hDE));
        fifo1.push_back(fl8(0, 8'hAD));
        fifo1.push_back(fl8(0, 8'hBE));
        fifo1.push_back(fl8(1, 8'hEF));
        exp_q1.push_back(32'hDEAD_BEEF);
        for (int i = 0; i < 6; i++) step();
        check("t4_err", 32'(err1), 32'd1);
        check("t4_queue_drained", 32'(exp_q1.size()), 32'd0);

        // Header-only packets and error counter saturation on a 2-bit counter.
        for (int i = 0; i < 3; i++) fifo2.push_back(fl(1, 10'(i)));
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_hdr_no_v", 32'(v2), 32'd0);
        end
        check("t6_hdr_err", 32'(err2), 32'd0);
        for (int i = 0; i < 5; i++) begin
            fifo2.push_back(fl(0, 10'h000));
            fifo2.push_back(fl(1, 10'h001));
        end
        for (int i = 0; i < 4; i++) step();
        check("t6_err_two", 32'(err2), 32'd2);
        for (int i = 0; i < 6; i++) step();
        check("t6_err_sat", 32'(err2), 32'd3);
        check("t6_no_v", 32'(v2), 32'd0);
        fifo2.push_back(fl(0, 10'h000));
        fifo2.push_back(fl(0, 10'h001));
        fifo2.push_back(fl(0, 10'h002));
        fifo2.push_back(fl(1, 10'h003));
        exp_q2.push_back(32'h0010_0803);
        for (int i = 0; i < 5; i++) step();
        check("t6_queue_drained", 32'(exp_q2.size()), 32'd0);
        check("t6_err_hold", 32'(err2), 32'd3);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
